// File: rtl/conv1_ofm_writer_if.sv
// Bundle between the conv1 output stage, the writer and the layer-1 feature-map RAM.
// The master side drives start/sample/ofm; the slave side is the writer, which drives the RAM and status outputs.
interface conv1_ofm_writer_if #(
    parameter int WOUT  = 128,
    parameter int CHOUT = 64,
    parameter int WIDTH = 16,
    parameter int LANES = 8
);
    localparam int BEATS  = CHOUT / LANES;
    localparam int PIX_W  = $clog2(WOUT * WOUT) + 1;
    localparam int ADDR_W = $clog2(WOUT * WOUT * BEATS);

    logic                     start;
    logic                     sample;
    logic [WIDTH-1:0]         ofm [CHOUT];
    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [LANES*WIDTH-1:0]   ram_wdata;
    logic                     ram_feedback;
    logic                     overflow;
    logic [PIX_W-1:0]         pix_count;

    modport master (
        output start, sample, ofm,
        input  ram_we, ram_addr, ram_wdata, ram_feedback, overflow, pix_count
    );

    modport slave (
        input  start, sample, ofm,
        output ram_we, ram_addr, ram_wdata, ram_feedback, overflow, pix_count
    );
endinterface

// File: rtl/conv1_ofm_writer.sv
// Captures conv1 output-pixel vectors into a ping-pong buffer and drains them into the
// layer-1 feature-map RAM as LANES-wide beats, raising ram_feedback once the layer is complete.
module conv1_ofm_writer #(
    parameter int WOUT  = 128,
    parameter int CHOUT = 64,
    parameter int WIDTH = 16,
    parameter int LANES = 8
) (
    input  logic               clk,
    input  logic               rst,
    conv1_ofm_writer_if.slave  bus
);
    localparam int BEATS  = CHOUT / LANES;
    localparam int PIX_W  = $clog2(WOUT * WOUT) + 1;
    localparam int ADDR_W = $clog2(WOUT * WOUT * BEATS);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CH_W   = (CHOUT > 1) ? $clog2(CHOUT) : 1;
    localparam logic [PIX_W-1:0]  TOTAL     = PIX_W'(WOUT * WOUT);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_reg;
    logic [1:0]              valid_reg;
    logic                    wr_ptr_reg;
    logic                    rd_ptr_reg;
    logic [BEAT_W-1:0]       beat_reg;
    logic [ADDR_W-1:0]       addr_cnt_reg;
    logic                    last_out_reg;
    logic                    ram_we_reg;
    logic [ADDR_W-1:0]       ram_addr_reg;
    logic [LANES*WIDTH-1:0]  ram_wdata_reg;
    logic                    ram_feedback_reg;
    logic                    overflow_reg;
    logic [PIX_W-1:0]        pix_count_reg;
    logic [WIDTH-1:0]        buf_reg [2][CHOUT];

    logic                    run;
    logic                    rd_last;
    logic                    wr_free;
    logic                    capture;
    logic                    drop;
    logic                    bypass;
    logic                    issue;
    logic                    issue_last;
    logic [LANES*WIDTH-1:0]  lane_next;

    // An entry finishing its last beat this cycle counts as free, so a back-to-back
    // sample is never dropped. When the drain is idle, beat 0 comes straight from ofm.
    always_comb begin
        run        = (state_reg == RUN);
        rd_last    = valid_reg[rd_ptr_reg] && (beat_reg == LAST_BEAT);
        wr_free    = !valid_reg[wr_ptr_reg] || (rd_last && (rd_ptr_reg == wr_ptr_reg));
        capture    = run && bus.sample && !bus.start && wr_free;
        drop       = run && bus.sample && !bus.start && !wr_free;
        bypass     = capture && !valid_reg[rd_ptr_reg];
        issue      = !bus.start && (valid_reg[rd_ptr_reg] || bypass);
        issue_last = issue && (beat_reg == LAST_BEAT);
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [CH_W-1:0] ch;
            assign ch = CH_W'(beat_reg) * CH_W'(LANES) + CH_W'(gi);
            assign lane_next[gi*WIDTH +: WIDTH] = bypass ? bus.ofm[ch] : buf_reg[rd_ptr_reg][ch];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int c = 0; c < CHOUT; c++) begin
                buf_reg[wr_ptr_reg][c] <= bus.ofm[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            valid_reg        <= 2'b00;
            wr_ptr_reg       <= 1'b0;
            rd_ptr_reg       <= 1'b0;
            beat_reg         <= '0;
            addr_cnt_reg     <= '0;
            last_out_reg     <= 1'b0;
            ram_we_reg       <= 1'b0;
            ram_addr_reg     <= '0;
            ram_wdata_reg    <= '0;
            ram_feedback_reg <= 1'b0;
            overflow_reg     <= 1'b0;
            pix_count_reg    <= '0;
        end else if (bus.start) begin
            state_reg        <= RUN;
            valid_reg        <= 2'b00;
            wr_ptr_reg       <= 1'b0;
            rd_ptr_reg       <= 1'b0;
            beat_reg         <= '0;
            addr_cnt_reg     <= '0;
            last_out_reg     <= 1'b0;
            ram_we_reg       <= 1'b0;
            ram_feedback_reg <= 1'b0;
            overflow_reg     <= 1'b0;
            pix_count_reg    <= '0;
        end else begin
            ram_we_reg   <= issue;
            last_out_reg <= issue_last;
            if (issue) begin
                ram_addr_reg  <= addr_cnt_reg;
                ram_wdata_reg <= lane_next;
                addr_cnt_reg  <= addr_cnt_reg + ADDR_W'(1);
                beat_reg      <= issue_last ? '0 : beat_reg + BEAT_W'(1);
            end
            // Release before capture: a capture into the entry just freed must win.
            if (issue_last) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg            <= ~rd_ptr_reg;
            end
            if (capture) begin
                if (!(bypass && issue_last)) begin
                    valid_reg[wr_ptr_reg] <= 1'b1;
                end
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            // Pixel count follows the final beat appearing on the RAM port.
            if (last_out_reg && (pix_count_reg < TOTAL)) begin
                pix_count_reg <= pix_count_reg + PIX_W'(1);
                if (pix_count_reg == TOTAL - PIX_W'(1)) begin
                    state_reg        <= DONE;
                    ram_feedback_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.ram_we       = ram_we_reg;
    assign bus.ram_addr     = ram_addr_reg;
    assign bus.ram_wdata    = ram_wdata_reg;
    assign bus.ram_feedback = ram_feedback_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.pix_count    = pix_count_reg;
endmodule

// File: tb/tb_conv1_ofm_writer.sv
// Directed bench for conv1_ofm_writer on a 4x4 layer: latency, ping-pong, overflow, layer completion and reset.
module tb_conv1_ofm_writer;
    localparam int WOUT   = 4;
    localparam int CHOUT  = 64;
    localparam int WIDTH  = 16;
    localparam int LANES  = 8;
    localparam int BEATS  = CHOUT / LANES;
    localparam int NPIX   = WOUT * WOUT;
    localparam int ADDR_W = $clog2(NPIX * BEATS);
    localparam int PIX_W  = $clog2(NPIX) + 1;
    localparam int DW     = LANES * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv1_ofm_writer_if #(.WOUT(WOUT), .CHOUT(CHOUT), .WIDTH(WIDTH), .LANES(LANES)) bus ();

    conv1_ofm_writer #(.WOUT(WOUT), .CHOUT(CHOUT), .WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int                c;
        logic [ADDR_W-1:0] a;
        logic [DW-1:0]     d;
    } wr_t;

    wr_t  wq[$];
    int   cyc     = 0;
    int   fb_rise = -1;
    logic fb_prev = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            wq.push_back('{cyc, bus.ram_addr, bus.ram_wdata});
            $display("write cyc=%0d addr=%0d data=%h", cyc, bus.ram_addr, bus.ram_wdata);
        end
        if (bus.ram_feedback === 1'b1 && fb_prev !== 1'b1) fb_rise = cyc;
        fb_prev = bus.ram_feedback;
    end

    function automatic logic [DW-1:0] exp_data(int base, int beat);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = WIDTH'(base + beat * LANES + k);
        return r;
    endfunction

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(int base, output int t);
        for (int c = 0; c < CHOUT; c++) bus.ofm[c] = WIDTH'(base + c);
        bus.sample = 1'b1;
        t = cyc;
        step();
        bus.sample = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(2);
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.ram_we); end
        checks++; if (bus.ram_addr !== '0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", bus.ram_addr); end
        checks++; if (bus.ram_wdata !== '0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", bus.ram_wdata); end
        checks++; if (bus.ram_feedback !== 1'b0) begin errors++; $display("FAIL reset_feedback got=%b exp=0", bus.ram_feedback); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        checks++; if (bus.pix_count !== '0) begin errors++; $display("FAIL reset_pix_count got=%0d exp=0", bus.pix_count); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        int t;
        pulse_start();
        wq.delete();
        send(0, t);
        step(7);
        checks++; if (bus.ram_we !== 1'b1 || bus.pix_count !== PIX_W'(0)) begin
            errors++; $display("FAIL single_last_beat we=%b pix=%0d exp we=1 pix=0", bus.ram_we, bus.pix_count); end
        step();
        checks++; if (bus.ram_we !== 1'b0 || bus.pix_count !== PIX_W'(1)) begin
            errors++; $display("FAIL single_pix_count we=%b pix=%0d exp we=0 pix=1", bus.ram_we, bus.pix_count); end
        step(3);
        checks++; if (wq.size() != BEATS) begin errors++; $display("FAIL single_count got=%0d exp=%0d", wq.size(), BEATS); end
        for (int j = 0; j < BEATS && j < wq.size(); j++) begin
            checks++; if (wq[j].c != t + 1 + j || wq[j].a !== ADDR_W'(j)) begin
                errors++; $display("FAIL single_addr beat=%0d got cyc=%0d addr=%0d exp cyc=%0d addr=%0d", j, wq[j].c, wq[j].a, t + 1 + j, j); end
            checks++; if (wq[j].d !== exp_data(0, j)) begin
                errors++; $display("FAIL single_data beat=%0d got=%h exp=%h", j, wq[j].d, exp_data(0, j)); end
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        pulse_start();
        wq.delete();
        send(16'h100, t0);
        step(BEATS - 1);
        send(16'h200, t1);
        step(BEATS + 4);
        checks++; if (t1 != t0 + BEATS) begin errors++; $display("FAIL b2b_timing got=%0d exp=%0d", t1 - t0, BEATS); end
        checks++; if (wq.size() != 2 * BEATS) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", wq.size(), 2 * BEATS); end
        for (int j = 0; j < 2 * BEATS && j < wq.size(); j++) begin
            checks++; if (wq[j].c != t0 + 1 + j || wq[j].a !== ADDR_W'(j) ||
                          wq[j].d !== exp_data(j < BEATS ? 16'h100 : 16'h200, j % BEATS)) begin
                errors++; $display("FAIL b2b_write idx=%0d got cyc=%0d addr=%0d data=%h exp cyc=%0d addr=%0d data=%h",
                    j, wq[j].c, wq[j].a, wq[j].d, t0 + 1 + j, j, exp_data(j < BEATS ? 16'h100 : 16'h200, j % BEATS)); end
        end
        checks++; if (bus.pix_count !== PIX_W'(2)) begin errors++; $display("FAIL b2b_pix_count got=%0d exp=2", bus.pix_count); end
    endtask

    task automatic test_overflow();
        int t0, t1, t2;
        pulse_start();
        wq.delete();
        send(16'h300, t0);
        send(16'h400, t1);
        send(16'h500, t2);
        step(2 * BEATS + 6);
        checks++; if (wq.size() != 2 * BEATS) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", wq.size(), 2 * BEATS); end
        for (int j = 0; j < 2 * BEATS && j < wq.size(); j++) begin
            checks++; if (wq[j].c != t0 + 1 + j || wq[j].a !== ADDR_W'(j) ||
                          wq[j].d !== exp_data(j < BEATS ? 16'h300 : 16'h400, j % BEATS)) begin
                errors++; $display("FAIL ovf_write idx=%0d got cyc=%0d addr=%0d data=%h exp cyc=%0d addr=%0d data=%h",
                    j, wq[j].c, wq[j].a, wq[j].d, t0 + 1 + j, j, exp_data(j < BEATS ? 16'h300 : 16'h400, j % BEATS)); end
        end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
        checks++; if (bus.pix_count !== PIX_W'(2)) begin errors++; $display("FAIL ovf_pix_count got=%0d exp=2", bus.pix_count); end
    endtask

    task automatic test_full_layer(int seed);
        int t [NPIX];
        pulse_start();
        checks++; if (bus.ram_feedback !== 1'b0 || bus.pix_count !== '0 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL layer_start_clear fb=%b pix=%0d ovf=%b exp 0/0/0", bus.ram_feedback, bus.pix_count, bus.overflow); end
        wq.delete();
        fb_rise = -1;
        for (int p = 0; p < NPIX; p++) begin
            send(seed + p * CHOUT, t[p]);
            step(26);
        end
        step(4);
        checks++; if (wq.size() != NPIX * BEATS) begin errors++; $display("FAIL layer_count got=%0d exp=%0d", wq.size(), NPIX * BEATS); end
        for (int j = 0; j < NPIX * BEATS && j < wq.size(); j++) begin
            checks++; if (wq[j].c != t[j / BEATS] + 1 + j % BEATS || wq[j].a !== ADDR_W'(j) ||
                          wq[j].d !== exp_data(seed + (j / BEATS) * CHOUT, j % BEATS)) begin
                errors++; $display("FAIL layer_write idx=%0d got cyc=%0d addr=%0d data=%h exp cyc=%0d addr=%0d data=%h",
                    j, wq[j].c, wq[j].a, wq[j].d, t[j / BEATS] + 1 + j % BEATS, j, exp_data(seed + (j / BEATS) * CHOUT, j % BEATS)); end
        end
        if (wq.size() == NPIX * BEATS) begin
            checks++; if (fb_rise != wq[NPIX * BEATS - 1].c + 1) begin
                errors++; $display("FAIL layer_feedback_rise got=%0d exp=%0d", fb_rise, wq[NPIX * BEATS - 1].c + 1); end
        end
        checks++; if (bus.ram_feedback !== 1'b1) begin errors++; $display("FAIL layer_feedback got=%b exp=1", bus.ram_feedback); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL layer_overflow got=%b exp=0", bus.overflow); end
        checks++; if (bus.pix_count !== PIX_W'(NPIX)) begin errors++; $display("FAIL layer_pix_count got=%0d exp=%0d", bus.pix_count, NPIX); end
    endtask

    task automatic test_reset_mid();
        int t;
        pulse_start();
        wq.delete();
        send(16'h700, t);
        step(3);
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== ADDR_W'(3)) begin
            errors++; $display("FAIL mid_beat3 we=%b addr=%0d exp we=1 addr=3", bus.ram_we, bus.ram_addr); end
        rst = 1'b0;
        #1;
        checks++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== '0 || bus.ram_wdata !== '0 ||
                      bus.pix_count !== '0 || bus.overflow !== 1'b0 || bus.ram_feedback !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs we=%b addr=%0d data=%h pix=%0d ovf=%b fb=%b exp all 0",
                bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.pix_count, bus.overflow, bus.ram_feedback); end
        step();
        rst = 1'b1;
        step();
        wq.delete();
        send(16'h800, t);
        step(BEATS + 4);
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL mid_no_writes got=%0d exp=0", wq.size()); end
        checks++; if (bus.pix_count !== '0) begin errors++; $display("FAIL mid_pix_count got=%0d exp=0", bus.pix_count); end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.sample = 1'b0;
        for (int c = 0; c < CHOUT; c++) bus.ofm[c] = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_layer(0);
        test_full_layer(16'h1000);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
